usb_packet_decoder: RTL and testbench
=====================================

# usb_packet_decoder

Downstream consumer of the FT245 receive stage. Takes the byte stream sampled from the FTDI FIFO together with the header/trailer recognition pulses, parses the packet body into 16-bit register commands and presents them one at a time to the register file over a valid/ready handshake. It also reports per-packet completion and error status to the control logic.

## Interface
Parameters:
- MAX_CMDS, 256: largest command count accepted in the length field.
- TIMEOUT_CYCLES, 65535: idle clocks between bytes before a packet is aborted (only with the watchdog compiled in).

Ports:
- clk, in, 1: system clock; the only clock.
- clrn, in, 1: asynchronous, active-low reset.
- rx_byte, in, 8: received byte; valid only when rx_valid is 1.
- rx_valid, in, 1: one-cycle pulse per received byte.
- pkt_start, in, 1: one-cycle pulse after the last header symbol is recognised.
- pkt_end, in, 1: one-cycle pulse after the last trailer symbol is recognised.
- req_valid, out, 1: a command is pending.
- req_ready, in, 1: the register file accepts the command.
- req_write, out, 1: 1 = write, 0 = read (address bit 15).
- req_addr, out, 15: register address.
- req_wdata, out, 16: write data; also carried, but don't-care, for reads.
- pkt_ok, out, 1: one-cycle pulse when a packet completes without error.
- pkt_err, out, 1: one-cycle pulse when a packet is aborted.
- err_code, out, 3: cause of the last abort; holds until the next pkt_start.
- pkt_busy, out, 1: high in every state except IDLE.

## Operation
- Packet body follows the header: LEN_HI, LEN_LO, then LEN commands of 4 bytes each (ADDR_HI, ADDR_LO, DATA_HI, DATA_LO), then trailer bytes. All fields are MSB first.
- States and transitions:
  - IDLE goes to LEN_HI on pkt_start.
  - LEN_HI goes to LEN_LO, which then goes to ADDR_HI, or to WAIT_TRL when LEN == 0.
  - ADDR_HI, ADDR_LO, DATA_HI and DATA_LO advance in order, one per rx_valid.
  - After DATA_LO: loop back to ADDR_HI while commands remain, otherwise go to WAIT_TRL.
  - WAIT_TRL ignores incoming bytes; pkt_end moves it to IDLE and pulses pkt_ok.
- Command counter is 16 bits. It is loaded from LEN and decremented at each DATA_LO.
- In IDLE all bytes and pkt_end are ignored.
- Error codes (each causes a pkt_err pulse and a return to IDLE, except where noted):
  - 1 LEN_OVER: LEN > MAX_CMDS, detected at LEN_LO.
  - 2 EARLY_END: pkt_end arrives in any state from LEN_HI to DATA_LO.
  - 3 OVERRUN: DATA_LO completes while req_valid is still high. The new command is dropped and the pending one is kept.
  - 4 RESYNC: pkt_start arrives in any non-IDLE state. The decoder restarts at LEN_HI instead of going to IDLE.
  - 5 TIMEOUT: watchdog expiry; only with the watchdog compiled in.
- A command already issued before an abort stays valid until accepted. Commands are never retracted.

## Timing
- Reset values: req_valid=0, req_write=0, req_addr=0, req_wdata=0, pkt_ok=0, pkt_err=0, err_code=0, pkt_busy=0, state=IDLE.
- req_valid rises 1 clk after the rx_valid carrying DATA_LO, with all req_* fields stable.
- The req_* fields hold until req_valid && req_ready; req_valid falls in the next cycle.
- pkt_ok and pkt_err each assert 1 clk after the triggering input, for exactly one cycle.
- Simultaneous events:
  - pkt_start together with rx_valid: pkt_start wins and the byte is dropped.
  - pkt_end together with rx_valid: pkt_end wins.
  - The final DATA_LO together with req_ready on the previous command: accepted, no overrun.
- Reset mid-packet returns to IDLE immediately with no pkt_err pulse.

## Configuration
- USB_PKT_DECODER_TIMEOUT_EN defined:
  - A 16-bit watchdog clears on every rx_valid and on pkt_start.
  - It counts only in non-IDLE states.
  - Reaching TIMEOUT_CYCLES aborts the packet with err_code 5.
- Undefined: no watchdog logic exists; a stalled packet waits indefinitely for bytes or a new pkt_start.

## Structure
- Package usb_pkt_pkg holds:
  - typedef enum state_t {IDLE, LEN_HI, LEN_LO, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WAIT_TRL};
  - typedef enum err_t {ERR_NONE=0, ERR_LEN_OVER=1, ERR_EARLY_END=2, ERR_OVERRUN=3, ERR_RESYNC=4, ERR_TIMEOUT=5};
  - the header/trailer symbol constants 8'h55 and 8'hAA, shared with the receive stage.
- One sub-module, usb_pkt_watchdog, holds the timeout counter. It is instantiated only under the macro.

## Test plan
- LEN=0x0002 with commands {8012,ABCD}, {0034,0000} and req_ready held high, then pkt_end:
  - required: a write to addr 0x012 with data 0xABCD, then a read of addr 0x034;
  - required: one pkt_ok and pkt_err never asserted.
- LEN=0x0000 then pkt_end: pkt_ok only, req_valid never rises.
- LEN=MAX_CMDS+1: pkt_err with err_code=1 one clk after the LEN_LO byte; subsequent bytes are ignored and pkt_busy=0.
- req_ready held low across two commands: the first command is held, pkt_err with err_code=3 is raised, and the second command is never presented.
- pkt_start after ADDR_HI: pkt_err with err_code=4, state goes to LEN_HI, and the following full packet completes with pkt_ok.
- With USB_PKT_DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=100, stop bytes after LEN_LO: pkt_err with err_code=5 exactly 100 clks after the last rx_valid.

Source files
------------

// File: rtl/usb_pkt_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkt_pkg
// Shared types and constants for the USB/FT245 packet path.
//   state_t     : packet decoder FSM states
//   err_t       : abort cause reported on err_code
//   SYM_HEADER  : header symbol, shared with the receive stage
//   SYM_TRAILER : trailer symbol, shared with the receive stage
// -----------------------------------------------------------------------------
package usb_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        ADDR_HI,
        ADDR_LO,
        DATA_HI,
        DATA_LO,
        WAIT_TRL
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_LEN_OVER  = 3'd1,
        ERR_EARLY_END = 3'd2,
        ERR_OVERRUN   = 3'd3,
        ERR_RESYNC    = 3'd4,
        ERR_TIMEOUT   = 3'd5
    } err_t;

    localparam logic [7:0] SYM_HEADER  = 8'h55;
    localparam logic [7:0] SYM_TRAILER = 8'hAA;

endpackage

// File: rtl/usb_pkt_watchdog.sv
// -----------------------------------------------------------------------------
// usb_pkt_watchdog
// Inter-byte timeout counter for usb_packet_decoder (only instantiated when
// USB_PKT_DECODER_TIMEOUT_EN is defined).
//   clk, clrn : clock, asynchronous active-low reset
//   active    : decoder is inside a packet; counter holds at zero otherwise
//   kick      : rx_valid or pkt_start; restarts the count
//   expired   : high in the cycle whose edge completes TIMEOUT_CYCLES idle clks
// -----------------------------------------------------------------------------
module usb_pkt_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic clrn,
    input  logic active,
    input  logic kick,
    output logic expired
);

    // Count is k after the k-th idle edge, so expiry is flagged one count
    // early to land pkt_err exactly TIMEOUT_CYCLES clks after the last byte.
    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= '0;
        end else if (!active || kick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign expired = active && !kick && (cnt_q == LAST);

endmodule

// File: rtl/usb_packet_decoder.sv
// -----------------------------------------------------------------------------
// usb_packet_decoder
// Parses the FT245 receive byte stream into 16-bit register commands:
// LEN_HI, LEN_LO, then LEN x {ADDR_HI, ADDR_LO, DATA_HI, DATA_LO}, MSB first.
// Commands go out one at a time on a valid/ready handshake; per-packet
// completion/abort is pulsed on pkt_ok/pkt_err with the cause on err_code.
//
// Ports:
//   clk, clrn            : clock, asynchronous active-low reset
//   rx_byte, rx_valid    : received byte and its one-cycle strobe
//   pkt_start, pkt_end   : header / trailer recognised pulses
//   req_valid, req_ready : command handshake to the register file
//   req_write, req_addr  : address bit 15 (1 = write) and 15-bit address
//   req_wdata            : write data (don't-care for reads)
//   pkt_ok, pkt_err      : one-cycle completion / abort pulses
//   err_code             : cause of last abort, held until next pkt_start
//   pkt_busy             : decoder is not in IDLE
//
// Build option: define USB_PKT_DECODER_TIMEOUT_EN to add the inter-byte
// watchdog (err_code 5 after TIMEOUT_CYCLES idle clks inside a packet).
// -----------------------------------------------------------------------------
module usb_packet_decoder
    import usb_pkt_pkg::*;
#(
    parameter int unsigned MAX_CMDS       = 256,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        pkt_start,
    input  logic        pkt_end,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output logic [14:0] req_addr,
    output logic [15:0] req_wdata,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic [2:0]  err_code,
    output logic        pkt_busy
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535 for the 16-bit watchdog");
    end

    state_t      state_q, state_d;
    err_t        err_code_q, err_code_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  len_hi_q, addr_hi_q, addr_lo_q, data_hi_q;
    logic [15:0] len_word;
    logic        ok_d, err_d;
    logic        byte_take;
    logic        cmd_load;
    logic        wd_expired;

    assign len_word = {len_hi_q, rx_byte};
    assign pkt_busy = (state_q != IDLE);
    assign err_code = err_code_q;

`ifdef USB_PKT_DECODER_TIMEOUT_EN
    usb_pkt_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .clrn    (clrn),
        .active  (pkt_busy),
        .kick    (rx_valid || pkt_start),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: pkt_start > pkt_end > watchdog > rx_valid.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        cnt_d      = cnt_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        byte_take  = 1'b0;
        cmd_load   = 1'b0;

        if (pkt_start) begin
            state_d = LEN_HI;
            if (state_q == IDLE) begin
                err_code_d = ERR_NONE;
            end else begin
                err_d      = 1'b1;
                err_code_d = ERR_RESYNC;
            end
        end else if (pkt_end && state_q != IDLE) begin
            state_d = IDLE;
            if (state_q == WAIT_TRL) begin
                ok_d = 1'b1;
            end else begin
                err_d      = 1'b1;
                err_code_d = ERR_EARLY_END;
            end
        end else if (wd_expired) begin
            state_d    = IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else if (rx_valid) begin
            unique case (state_q)
                LEN_HI: begin
                    byte_take = 1'b1;
                    state_d   = LEN_LO;
                end
                LEN_LO: begin
                    if (32'(len_word) > MAX_CMDS) begin
                        state_d    = IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN_OVER;
                    end else if (len_word == 16'd0) begin
                        state_d = WAIT_TRL;
                    end else begin
                        cnt_d   = len_word;
                        state_d = ADDR_HI;
                    end
                end
                ADDR_HI: begin
                    byte_take = 1'b1;
                    state_d   = ADDR_LO;
                end
                ADDR_LO: begin
                    byte_take = 1'b1;
                    state_d   = DATA_HI;
                end
                DATA_HI: begin
                    byte_take = 1'b1;
                    state_d   = DATA_LO;
                end
                DATA_LO: begin
                    // A command accepted on this same edge frees the slot.
                    if (req_valid && !req_ready) begin
                        state_d    = IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_OVERRUN;
                    end else begin
                        cmd_load = 1'b1;
                        cnt_d    = cnt_q - 16'd1;
                        state_d  = (cnt_q == 16'd1) ? WAIT_TRL : ADDR_HI;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q      <= '0;
            len_hi_q   <= '0;
            addr_hi_q  <= '0;
            addr_lo_q  <= '0;
            data_hi_q  <= '0;
            err_code_q <= ERR_NONE;
            pkt_ok     <= 1'b0;
            pkt_err    <= 1'b0;
            req_valid  <= 1'b0;
            req_write  <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            err_code_q <= err_code_d;
            pkt_ok     <= ok_d;
            pkt_err    <= err_d;

            if (byte_take) begin
                unique case (state_q)
                    LEN_HI:  len_hi_q  <= rx_byte;
                    ADDR_HI: addr_hi_q <= rx_byte;
                    ADDR_LO: addr_lo_q <= rx_byte;
                    DATA_HI: data_hi_q <= rx_byte;
                    default: ;
                endcase
            end

            if (cmd_load) begin
                req_valid <= 1'b1;
                req_write <= addr_hi_q[7];
                req_addr  <= {addr_hi_q[6:0], addr_lo_q};
                req_wdata <= {data_hi_q, rx_byte};
            end else if (req_ready) begin
                req_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_packet_decoder.sv
// -----------------------------------------------------------------------------
// tb_usb_packet_decoder
// Directed bench for usb_packet_decoder. Expected commands are queued when
// their DATA_LO byte is driven and checked when the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_usb_packet_decoder;

    localparam int unsigned MAX_CMDS = 256;
    localparam int unsigned TIMEOUT  = 100;

    typedef struct packed {
        logic        write;
        logic [14:0] addr;
        logic [15:0] data;
    } cmd_t;

    logic        clk = 1'b0;
    logic        clrn;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        pkt_start;
    logic        pkt_end;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [14:0] req_addr;
    logic [15:0] req_wdata;
    logic        pkt_ok;
    logic        pkt_err;
    logic [2:0]  err_code;
    logic        pkt_busy;

    int   tests = 0;
    int   fails = 0;
    int   ok_seen = 0;
    int   err_seen = 0;
    int   accepted = 0;
    cmd_t exp_q[$];

    usb_packet_decoder #(
        .MAX_CMDS       (MAX_CMDS),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .pkt_start (pkt_start),
        .pkt_end   (pkt_end),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .pkt_ok    (pkt_ok),
        .pkt_err   (pkt_err),
        .err_code  (err_code),
        .pkt_busy  (pkt_busy)
    );

    always #5 clk = ~clk;

    // Handshake monitor / scoreboard, sampled on the inactive edge.
    always @(negedge clk) begin
        if (clrn) begin
            if (pkt_ok)  ok_seen++;
            if (pkt_err) err_seen++;
            if (req_valid && req_ready) begin
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL cmd_unexpected: got %0h expected none",
                           {req_write, req_addr, req_wdata});
                end
                if (exp_q.size() > 0) begin
                    cmd_t e;
                    e = exp_q.pop_front();
                    tests++;
                    assert ({req_write, req_addr, req_wdata} === e) else begin
                        fails++;
                        $error("FAIL cmd_fields: got %0h expected %0h",
                               {req_write, req_addr, req_wdata}, e);
                    end
                end
                accepted++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic start_pulse();
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
    endtask

    task automatic end_pulse();
        pkt_end = 1'b1;
        tick();
        pkt_end = 1'b0;
    endtask

    task automatic send_len(input logic [15:0] len);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [15:0] d, input bit expect_it);
        if (expect_it) exp_q.push_back({a[15], a[14:0], d});
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
    endtask

    initial begin
        int exp_err;
        clrn      = 1'b0;
        rx_byte   = '0;
        rx_valid  = 1'b0;
        pkt_start = 1'b0;
        pkt_end   = 1'b0;
        req_ready = 1'b1;

        // Reset values
        #12;
        check("rst_req_valid", req_valid, 0);
        check("rst_req_write", req_write, 0);
        check("rst_req_addr",  req_addr,  0);
        check("rst_req_wdata", req_wdata, 0);
        check("rst_pkt_ok",    pkt_ok,    0);
        check("rst_pkt_err",   pkt_err,   0);
        check("rst_err_code",  err_code,  0);
        check("rst_pkt_busy",  pkt_busy,  0);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        tick();

        // Two commands, ready high
        start_pulse();
        check("a_busy", pkt_busy, 1);
        send_len(16'h0002);
        send_cmd(16'h8012, 16'hABCD, 1'b1);
        check("a_valid1", req_valid, 1);
        check("a_write1", req_write, 1);
        check("a_addr1",  req_addr,  15'h012);
        check("a_data1",  req_wdata, 16'hABCD);
        send_cmd(16'h0034, 16'h0000, 1'b1);
        check("a_write2", req_write, 0);
        check("a_addr2",  req_addr,  15'h034);
        send_byte(8'hAA);
        send_byte(8'hAA);
        check("a_no_ok_early", pkt_ok, 0);
        end_pulse();
        check("a_pkt_ok", pkt_ok, 1);
        check("a_busy_done", pkt_busy, 0);
        tick();
        check("a_ok_width", pkt_ok, 0);
        check("a_accepted", accepted, 2);
        check("a_err_none", err_seen, 0);

        // LEN = 0
        start_pulse();
        send_len(16'h0000);
        check("z_busy_wait", pkt_busy, 1);
        check("z_no_valid", req_valid, 0);
        end_pulse();
        check("z_pkt_ok", pkt_ok, 1);
        check("z_accepted", accepted, 2);

        // LEN = MAX_CMDS + 1
        start_pulse();
        send_len(16'(MAX_CMDS + 1));
        check("lo_pkt_err", pkt_err, 1);
        check("lo_code", err_code, 1);
        check("lo_busy", pkt_busy, 0);
        send_cmd(16'h8001, 16'h1234, 1'b0);
        check("lo_err_width", pkt_err, 0);
        check("lo_busy_after", pkt_busy, 0);
        check("lo_no_valid", req_valid, 0);

        // Overrun with ready low
        req_ready = 1'b0;
        start_pulse();
        send_len(16'h0002);
        send_cmd(16'h8001, 16'h1111, 1'b1);
        check("ov_valid1", req_valid, 1);
        send_cmd(16'h8002, 16'h2222, 1'b0);
        check("ov_pkt_err", pkt_err, 1);
        check("ov_code", err_code, 3);
        check("ov_busy", pkt_busy, 0);
        check("ov_held_valid", req_valid, 1);
        check("ov_held_addr", req_addr, 15'h001);
        check("ov_held_data", req_wdata, 16'h1111);
        req_ready = 1'b1;
        tick();
        check("ov_drained", req_valid, 0);
        check("ov_code_hold", err_code, 3);
        check("ov_accepted", accepted, 3);

        // Resync after ADDR_HI, then full packet from LEN_HI
        start_pulse();
        send_len(16'h0001);
        send_byte(8'h80);
        start_pulse();
        check("rs_pkt_err", pkt_err, 1);
        check("rs_code", err_code, 4);
        check("rs_busy", pkt_busy, 1);
        send_len(16'h0001);
        send_cmd(16'h8055, 16'h5A5A, 1'b1);
        end_pulse();
        check("rs_pkt_ok", pkt_ok, 1);

        // Early end
        start_pulse();
        check("ee_code_clear", err_code, 0);
        send_len(16'h0001);
        send_byte(8'h12);
        end_pulse();
        check("ee_pkt_err", pkt_err, 1);
        check("ee_code", err_code, 2);

        // pkt_start with rx_valid: byte dropped
        rx_byte   = 8'h05;
        rx_valid  = 1'b1;
        pkt_start = 1'b1;
        tick();
        rx_valid  = 1'b0;
        pkt_start = 1'b0;
        check("sb_code_clear", err_code, 0);
        send_len(16'h0001);
        check("sb_no_err", pkt_err, 0);
        send_cmd(16'h0077, 16'h1234, 1'b1);
        end_pulse();
        check("sb_pkt_ok", pkt_ok, 1);

        // Final DATA_LO on the same edge the previous command is accepted
        req_ready = 1'b0;
        start_pulse();
        send_len(16'h0002);
        send_cmd(16'h8100, 16'hC0DE, 1'b1);
        exp_q.push_back({1'b1, 15'h0200, 16'hBEEF});
        send_byte(8'h82);
        send_byte(8'h00);
        send_byte(8'hBE);
        req_ready = 1'b1;
        send_byte(8'hEF);
        check("sim_no_err", pkt_err, 0);
        check("sim_valid2", req_valid, 1);
        check("sim_addr2", req_addr, 15'h0200);
        end_pulse();
        check("sim_pkt_ok", pkt_ok, 1);

        // Reset mid-packet
        start_pulse();
        send_len(16'h0001);
        send_byte(8'h80);
        clrn = 1'b0;
        #1;
        check("rm_busy", pkt_busy, 0);
        check("rm_no_err", pkt_err, 0);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        tick();
        check("rm_no_err_after", pkt_err, 0);

        // pkt_end in IDLE is ignored
        end_pulse();
        check("ie_no_ok", pkt_ok, 0);
        check("ie_no_err", pkt_err, 0);
        exp_err = 4;

`ifdef USB_PKT_DECODER_TIMEOUT_EN
        // Watchdog: pkt_err exactly TIMEOUT clks after last byte
        start_pulse();
        send_len(16'h0001);
        repeat (TIMEOUT - 1) tick();
        check("to_not_yet", pkt_err, 0);
        tick();
        check("to_pkt_err", pkt_err, 1);
        check("to_code", err_code, 5);
        check("to_busy", pkt_busy, 0);
        exp_err = 5;
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("end_queue_empty", exp_q.size(), 0);
        check("end_accepted", accepted, 7);
        check("end_ok_count", ok_seen, 5);
        check("end_err_count", err_seen, exp_err);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
